// File: rtl/mem_responder_pkg.sv
// Shared CPU control-word definitions used by the memory responder:
// control_signal strobe positions and the responder FSM encoding.
package mem_responder_pkg;

  localparam int CTRL_W      = 32;
  localparam int CTRL_MEM_RD = 1;
  localparam int CTRL_MEM_WR = 3;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_e;

  function automatic mem_op_e strobe_to_op(input logic wr);
    return wr ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous word RAM. The read port is registered and only updates
// on a read, so it doubles as the "holds last read" output register.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Contents are never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: detects read/write strobe edges from the control word,
// waits a programmable number of cycles, then accesses mem_array and pulses mem_ready.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 2,
  parameter int RD_BIT      = CTRL_MEM_RD,
  parameter int WR_BIT      = CTRL_MEM_WR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] control_signal,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_from_mbr,
  output logic [DATA_W-1:0] data_to_mbr,
  output logic              mem_ready,
  output logic              busy,
  output logic              access_err,
  output logic              req_drop
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES);

  resp_state_e       state;
  resp_state_e       state_next;
  logic              rd;
  logic              wr;
  logic              req;
  logic              req_q;
  logic              req_edge;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  mem_op_e           op_q;
  logic              accept;
  logic              access;
  logic              err_set;
  logic              drop_set;
  logic              mem_we;
  logic              mem_re;
  logic              ctrl_unused;

  assign rd          = control_signal[RD_BIT];
  assign wr          = control_signal[WR_BIT];
  assign req         = rd | wr;
  assign req_edge    = req & ~req_q;
  assign ctrl_unused = ^control_signal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    access     = 1'b0;
    err_set    = 1'b0;
    drop_set   = 1'b0;
    case (state)
      IDLE: begin
        if (req_edge) begin
          if (rd && wr) begin
            err_set = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        drop_set = req_edge;
        if (cnt == '0) begin
          access     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        drop_set   = req_edge;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latches and wait counter; addr/data may move after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= 1'b0;
      cnt        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      op_q       <= OP_READ;
      mem_ready  <= 1'b0;
      access_err <= 1'b0;
      req_drop   <= 1'b0;
    end else begin
      req_q      <= req;
      mem_ready  <= access;
      access_err <= err_set;
      req_drop   <= drop_set;
      if (accept) begin
        addr_q <= addr;
        data_q <= data_from_mbr;
        op_q   <= strobe_to_op(wr);
        cnt    <= CNT_INIT;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // A reset coinciding with the access cycle must not commit a write.
  assign mem_we = access && (op_q == OP_WRITE) && !rst;
  assign mem_re = access && (op_q == OP_READ) && !rst;
  assign busy   = (state != IDLE);

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem_array (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .re   (mem_re),
    .addr (addr_q),
    .wdata(data_q),
    .rdata(data_to_mbr)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table and WAIT_STATES=0 sequence,
// then random traffic checked against a transaction-level model.
module tb_mem_responder;

  localparam int WS_A = 2;
  localparam int WS_B = 0;

  typedef struct {
    bit          rst;
    bit          rd;
    bit          wr;
    logic [7:0]  addr;
    logic [15:0] data;
    bit          ready;
    bit          busy;
    bit          err;
    bit          drop;
    logic [15:0] dout;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ctrl_a = '0;
  logic [31:0] ctrl_b = '0;
  logic [7:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] dout_a, dout_b;
  logic        ready_a, ready_b, busy_a, busy_b, err_a, err_b, drop_a, drop_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state
  bit          m_req_q;
  bit          m_active;
  int          m_done;
  bit          m_wr;
  logic [7:0]  m_addr;
  logic [15:0] m_data;
  logic [15:0] m_mem [256];
  bit          m_known [256];
  logic [15:0] m_dout;
  bit          m_dout_known;
  bit          e_ready, e_busy, e_err, e_drop;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(WS_A), .RD_BIT(1), .WR_BIT(3)) dut_a (
    .clk(clk), .rst(rst), .control_signal(ctrl_a), .addr(addr), .data_from_mbr(wdata),
    .data_to_mbr(dout_a), .mem_ready(ready_a), .busy(busy_a), .access_err(err_a),
    .req_drop(drop_a)
  );

  mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(WS_B), .RD_BIT(1), .WR_BIT(3)) dut_b (
    .clk(clk), .rst(rst), .control_signal(ctrl_b), .addr(addr), .data_from_mbr(wdata),
    .data_to_mbr(dout_b), .mem_ready(ready_b), .busy(busy_b), .access_err(err_b),
    .req_drop(drop_b)
  );

  function automatic vec_t mk(bit r, bit rd, bit wr, logic [7:0] a, logic [15:0] d,
                              bit rdy, bit bsy, bit er, bit dr, logic [15:0] q);
    vec_t v;
    v.rst = r; v.rd = rd; v.wr = wr; v.addr = a; v.data = d;
    v.ready = rdy; v.busy = bsy; v.err = er; v.drop = dr; v.dout = q;
    return v;
  endfunction

  // Drive one cycle of inputs to instance A (sel=0) or B (sel=1); returns after the edge.
  task automatic applyStimulus(input bit sel, input bit r, input bit rd, input bit wr,
                               input logic [7:0] a, input logic [15:0] d);
    logic [31:0] c;
    @(negedge clk);
    c = '0;
    c[1] = rd;
    c[3] = wr;
    rst    = r;
    addr   = a;
    wdata  = d;
    ctrl_a = sel ? 32'h0 : c;
    ctrl_b = sel ? c : 32'h0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic checkAll(input string tag, input bit sel, input bit rdy, input bit bsy,
                          input bit er, input bit dr, input logic [15:0] q, input bit chk_q);
    checkOutput({tag, ".mem_ready"},  16'(sel ? ready_b : ready_a), 16'(rdy));
    checkOutput({tag, ".busy"},       16'(sel ? busy_b : busy_a),   16'(bsy));
    checkOutput({tag, ".access_err"}, 16'(sel ? err_b : err_a),     16'(er));
    checkOutput({tag, ".req_drop"},   16'(sel ? drop_b : drop_a),   16'(dr));
    if (chk_q) checkOutput({tag, ".data_to_mbr"}, sel ? dout_b : dout_a, q);
  endtask

  // Transaction-level reference: a request accepted at edge p completes at edge p+1+WS,
  // and the responder is busy from p through that completion edge.
  task automatic modelStep(input bit r, input bit rd, input bit wr,
                           input logic [7:0] a, input logic [15:0] d);
    bit was_busy, edge_seen;
    e_ready = 0; e_err = 0; e_drop = 0;
    if (r) begin
      m_req_q = 0; m_active = 0; m_dout = '0; m_dout_known = 1; e_busy = 0;
      return;
    end
    was_busy  = m_active && (cyc - 1 <= m_done);
    edge_seen = (rd || wr) && !m_req_q;
    m_req_q   = rd || wr;
    if (edge_seen) begin
      if (was_busy) e_drop = 1;
      else if (rd && wr) e_err = 1;
      else begin
        m_active = 1; m_done = cyc + 1 + WS_A; m_wr = wr; m_addr = a; m_data = d;
      end
    end
    if (m_active && cyc == m_done) begin
      e_ready = 1;
      if (m_wr) begin
        m_mem[m_addr] = m_data; m_known[m_addr] = 1;
      end else begin
        m_dout = m_mem[m_addr]; m_dout_known = m_known[m_addr];
      end
    end
    e_busy = m_active && cyc <= m_done;
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    bit r, rd, wr;
    logic [7:0] a;
    logic [15:0] d;

    // Rows: rst rd wr addr data | ready busy err drop dout
    vecs.push_back(mk(1,0,0,8'h00,16'h0000, 0,0,0,0,16'h0000)); // reset
    vecs.push_back(mk(0,0,1,8'h10,16'hBEEF, 0,1,0,0,16'h0000)); // write BEEF
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,1,0,0,16'h0000));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,1,0,0,16'h0000));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 1,1,0,0,16'h0000));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,0,0,0,16'h0000));
    vecs.push_back(mk(0,1,0,8'h10,16'h0000, 0,1,0,0,16'h0000)); // read back
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,1,0,0,16'h0000));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,1,0,0,16'h0000));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 1,1,0,0,16'hBEEF));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,0,0,0,16'hBEEF));
    vecs.push_back(mk(0,1,1,8'h10,16'h0000, 0,0,1,0,16'hBEEF)); // RD+WR together
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,0,0,0,16'hBEEF));
    vecs.push_back(mk(0,1,0,8'h10,16'h0000, 0,1,0,0,16'hBEEF));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,1,0,0,16'hBEEF));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,1,0,0,16'hBEEF));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 1,1,0,0,16'hBEEF));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,0,0,0,16'hBEEF));
    vecs.push_back(mk(0,1,0,8'h10,16'h0000, 0,1,0,0,16'hBEEF)); // edge during WAIT
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,1,0,0,16'hBEEF));
    vecs.push_back(mk(0,1,0,8'h10,16'h0000, 0,1,0,1,16'hBEEF));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 1,1,0,0,16'hBEEF));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,0,0,0,16'hBEEF));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,0,0,0,16'hBEEF));
    for (int i = 0; i < 10; i++) begin                           // RD held 10 cycles
      vecs.push_back(mk(0,1,0,8'h10,16'h0000, (i == 3), (i <= 3), 0,0,16'hBEEF));
    end
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,0,0,0,16'hBEEF));
    vecs.push_back(mk(0,1,0,8'h10,16'h0000, 0,1,0,0,16'hBEEF));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,1,0,0,16'hBEEF));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,1,0,0,16'hBEEF));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 1,1,0,0,16'hBEEF));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,0,0,0,16'hBEEF));
    vecs.push_back(mk(0,0,1,8'h20,16'h5A5A, 0,1,0,0,16'hBEEF)); // prior contents
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,1,0,0,16'hBEEF));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,1,0,0,16'hBEEF));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 1,1,0,0,16'hBEEF));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,0,0,0,16'hBEEF));
    vecs.push_back(mk(0,0,1,8'h20,16'h1234, 0,1,0,0,16'hBEEF)); // write aborted by reset
    vecs.push_back(mk(1,0,0,8'h00,16'h0000, 0,0,0,0,16'h0000));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,0,0,0,16'h0000));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,0,0,0,16'h0000));
    vecs.push_back(mk(0,1,0,8'h20,16'h0000, 0,1,0,0,16'h0000));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,1,0,0,16'h0000));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,1,0,0,16'h0000));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 1,1,0,0,16'h5A5A));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,0,0,0,16'h5A5A));
    vecs.push_back(mk(1,1,0,8'h10,16'h0000, 0,0,0,0,16'h0000)); // strobe held through reset
    vecs.push_back(mk(0,1,0,8'h10,16'h0000, 0,1,0,0,16'h0000));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,1,0,0,16'h0000));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,1,0,0,16'h0000));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 1,1,0,0,16'hBEEF));
    vecs.push_back(mk(0,0,0,8'h00,16'h0000, 0,0,0,0,16'hBEEF));

    $display("[TB] directed table, WAIT_STATES=%0d, %0d rows", WS_A, vecs.size());
    foreach (vecs[i]) begin
      v = vecs[i];
      applyStimulus(0, v.rst, v.rd, v.wr, v.addr, v.data);
      checkAll($sformatf("row%0d", i), 0, v.ready, v.busy, v.err, v.drop, v.dout, 1);
    end

    // WAIT_STATES=0 instance: write then read 8'hFF, with an edge during RESP dropped.
    $display("[TB] zero wait-state sequence");
    applyStimulus(1, 1, 0, 0, 8'h00, 16'h0000); checkAll("b.rst",  1, 0,0,0,0,16'h0000, 1);
    applyStimulus(1, 0, 0, 1, 8'hFF, 16'hC3C3); checkAll("b.wr0",  1, 0,1,0,0,16'h0000, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 16'h0000); checkAll("b.wr1",  1, 1,1,0,0,16'h0000, 1);
    applyStimulus(1, 0, 1, 0, 8'hFF, 16'h0000); checkAll("b.resp", 1, 0,0,0,1,16'h0000, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 16'h0000); checkAll("b.idle", 1, 0,0,0,0,16'h0000, 1);
    applyStimulus(1, 0, 1, 0, 8'hFF, 16'h0000); checkAll("b.rd0",  1, 0,1,0,0,16'h0000, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 16'h0000); checkAll("b.rd1",  1, 1,1,0,0,16'hC3C3, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 16'h0000); checkAll("b.rd2",  1, 0,0,0,0,16'hC3C3, 1);

    // Random traffic on instance A against the model.
    $display("[TB] random traffic");
    for (int i = 0; i < 256; i++) m_known[i] = 0;
    applyStimulus(0, 1, 0, 0, 8'h00, 16'h0000);
    modelStep(1, 0, 0, 8'h00, 16'h0000);
    checkAll("rnd.rst", 0, e_ready, e_busy, e_err, e_drop, m_dout, m_dout_known);
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      rd = ($urandom_range(0, 2) == 0);
      wr = ($urandom_range(0, 3) == 0);
      a  = 8'($urandom_range(0, 7));
      d  = 16'($urandom);
      applyStimulus(0, r, rd, wr, a, d);
      modelStep(r, rd, wr, a, d);
      checkAll($sformatf("rnd%0d", i), 0, e_ready, e_busy, e_err, e_drop, m_dout, m_dout_known);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
